// File: rtl/cl_fmt_pkg.sv
// Cache-line format shared by the pre-AFU and post-AFU stages: 16-bit head
// (length + last flag) above a 496-bit sample payload.
package cl_fmt_pkg;

   localparam int CL           = 512;
   localparam int CL_HEAD      = 16;
   localparam int CL_PAYLOAD   = CL - CL_HEAD;
   localparam int w_len_CLHead = 10;
   localparam int CL_LAST_BIT  = CL - 1 - 5;
   localparam int CL_LEN_LSB   = CL - CL_HEAD;

   typedef logic [CL_HEAD-1:0]      cl_head_t;
   typedef logic [w_len_CLHead-1:0] cl_len_t;

   // Head bits are numbered relative to CL_LEN_LSB, so the last flag sits at bit 10.
   function automatic cl_head_t cl_head(input cl_len_t len, input logic last);
      cl_head_t h;
      h = '0;
      h[w_len_CLHead-1:0] = len;
      h[CL_LAST_BIT-CL_LEN_LSB] = last;
      return h;
   endfunction

endpackage

// File: rtl/st2cl_accum.sv
// Payload accumulator: indexed sample writes into a cache-line payload register.
// o_merged already contains the sample being written this cycle.
module st2cl_accum
   import cl_fmt_pkg::*;
#(
   parameter int ST = 12,
   parameter int N  = 41,
   parameter int IW = 6
) (
   input  logic                  clk,
   input  logic                  rst_n_sync,
   input  logic                  i_wr,
   input  logic [IW-1:0]         i_idx,
   input  logic [ST-1:0]         i_data,
   input  logic                  i_clr,
   output logic [CL_PAYLOAD-1:0] o_merged
);

   logic [CL_PAYLOAD-1:0] r_payload;
   logic [CL_PAYLOAD-1:0] w_merged;

   // Overlay the incoming sample on the stored payload at its slot.
   always_comb begin
      w_merged = r_payload;
      for (int k = 0; k < N; k++) begin
         w_merged[k*ST +: ST] = (i_wr && (i_idx == IW'(k))) ? i_data : r_payload[k*ST +: ST];
      end
   end

   // Clear wins over write: a completing sample leaves only via o_merged.
   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         r_payload <= '0;
      end else if (i_clr) begin
         r_payload <= '0;
      end else if (i_wr) begin
         r_payload <= w_merged;
      end
   end

   assign o_merged = w_merged;

endmodule

// File: rtl/st2cl_post_afu.sv
// AFU output side: packs the sop/eop framed ST sample stream into 512-bit
// cache lines and writes them to the post-AFU CL FIFO.
module st2cl_post_afu
   import cl_fmt_pkg::*;
#(
   parameter int ST        = 12,
   parameter int ST_PER_CL = CL_PAYLOAD / ST
) (
   input  logic          clk,
   input  logic          rst_n_sync,
   input  logic [ST-1:0] sink_data,
   input  logic          sink_valid,
   input  logic          sink_sop,
   input  logic          sink_eop,
   output logic          sink_ready,
   input  logic          ff_almost_full,
   output logic          ff_wrreq,
   output logic [CL-1:0] ff_data,
   output logic          ff_wr_finish,
   output logic          err_proto
);

   localparam int CW = $clog2(ST_PER_CL + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PACK = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   generate
      if ((ST_PER_CL * ST > CL_PAYLOAD) || (ST_PER_CL > (1 << w_len_CLHead) - 1)) begin : g_bad_cfg
         $error("st2cl_post_afu: ST_PER_CL does not fit the cache-line format");
      end
   endgenerate

   logic [1:0]            r_state;
   logic [CW-1:0]         r_cnt;
   logic                  r_ready_en;
   logic                  r_wrreq;
   logic [CL-1:0]         r_data;
   logic                  r_wr_last;
   logic                  r_finish;
   logic                  r_err;

   logic                  w_beat;
   logic [1:0]            w_state_nxt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_acc_wr;
   logic                  w_emit;
   logic                  w_last;
   logic                  w_err;
   cl_len_t               w_len;
   logic [CL_PAYLOAD-1:0] w_merged;

   assign sink_ready = r_ready_en & ~ff_almost_full;
   assign w_beat     = sink_valid & sink_ready;
   assign w_len      = cl_len_t'(r_cnt) + cl_len_t'(1'b1);

   // Framing FSM: decides where each beat lands and when a line is complete.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_wr    = 1'b0;
      w_emit      = 1'b0;
      w_last      = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_beat) begin
               if (!sink_sop) begin
                  w_err = 1'b1;
               end else if (sink_eop) begin
                  w_acc_wr    = 1'b1;
                  w_emit      = 1'b1;
                  w_last      = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_FIN;
               end else begin
                  w_acc_wr    = 1'b1;
                  w_cnt_nxt   = CW'(1);
                  w_state_nxt = S_PACK;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_PACK: begin
            if (w_beat) begin
               w_acc_wr = 1'b1;
               w_err    = sink_sop;
               if (sink_eop) begin
                  w_emit      = 1'b1;
                  w_last      = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_FIN;
               end else if (r_cnt == CW'(ST_PER_CL - 1)) begin
                  w_emit    = 1'b1;
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end else begin
               w_state_nxt = S_PACK;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   st2cl_accum #(
      .ST (ST),
      .N  (ST_PER_CL),
      .IW (CW)
   ) u_accum (
      .clk        (clk),
      .rst_n_sync (rst_n_sync),
      .i_wr       (w_acc_wr),
      .i_idx      (r_cnt),
      .i_data     (sink_data),
      .i_clr      (w_emit),
      .o_merged   (w_merged)
   );

   // State, write strobe and pulses; a completed line is written unconditionally.
   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ready_en <= 1'b0;
         r_wrreq    <= 1'b0;
         r_data     <= '0;
         r_wr_last  <= 1'b0;
         r_finish   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ready_en <= (w_state_nxt != S_FIN);
         r_wrreq    <= w_emit;
         r_wr_last  <= w_emit & w_last;
         r_finish   <= r_wrreq & r_wr_last;
         r_err      <= w_err;
         if (w_emit) begin
            r_data <= {cl_head(w_len, w_last), w_merged};
         end
      end
   end

   assign ff_wrreq     = r_wrreq;
   assign ff_data      = r_data;
   assign ff_wr_finish = r_finish;
   assign err_proto    = r_err;

endmodule
